rule_stream_arbiter: RTL and testbench

//  Packet-atomic round-robin arbiter merging NUM_PORTS 64-bit rule streams into one 64-bit stream.

---
 rtl/rule_stream_arbiter.sv | 139 +++++++++++++
 tb/tb_rule_stream_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rule_stream_arbiter.sv
// Packet-atomic round-robin arbiter merging NUM_PORTS 64-bit rule streams into one.
// Optional per-port completed-packet counters are built when RULE_ARB_STATS_EN is defined.
module rule_stream_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int CNT_W     = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_PORTS-1:0]         in_rule_sop,
    input  logic [NUM_PORTS-1:0]         in_rule_eop,
    input  logic [NUM_PORTS*3-1:0]       in_rule_empty,
    input  logic [NUM_PORTS-1:0]         in_rule_valid,
    input  logic [NUM_PORTS*64-1:0]      in_rule_data,
    output logic [NUM_PORTS-1:0]         in_rule_ready,
    output logic                         out_rule_sop,
    output logic                         out_rule_eop,
    output logic [2:0]                   out_rule_empty,
    output logic                         out_rule_valid,
    output logic [63:0]                  out_rule_data,
    input  logic                         out_rule_ready,
    output logic [$clog2(NUM_PORTS)-1:0] cur_grant,
    output logic [NUM_PORTS*CNT_W-1:0]   pkt_cnt
);
    localparam int GW = $clog2(NUM_PORTS);

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [GW-1:0] r_grant;
    logic [GW-1:0] r_last_grant;
    logic [GW-1:0] w_grant_next;
    logic [GW-1:0] w_last_grant_next;
    logic [GW-1:0] w_pick;
    logic          w_found;
    logic          w_busy;
    logic          w_xfer_eop;

    logic          w_sop_arr   [NUM_PORTS];
    logic          w_eop_arr   [NUM_PORTS];
    logic          w_valid_arr [NUM_PORTS];
    logic [2:0]    w_empty_arr [NUM_PORTS];
    logic [63:0]   w_data_arr  [NUM_PORTS];

    // Reset gates the grant combinationally so a mid-packet rst drops it at once.
    assign w_busy = (r_state == S_BUSY) && !rst;

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign w_sop_arr[gi]     = in_rule_sop[gi];
            assign w_eop_arr[gi]     = in_rule_eop[gi];
            assign w_valid_arr[gi]   = in_rule_valid[gi];
            assign w_empty_arr[gi]   = in_rule_empty[3*gi +: 3];
            assign w_data_arr[gi]    = in_rule_data[64*gi +: 64];
            assign in_rule_ready[gi] = w_busy && (r_grant == GW'(gi)) && out_rule_ready;
        end
    endgenerate

    assign out_rule_valid = w_busy && w_valid_arr[r_grant];
    assign out_rule_sop   = w_sop_arr[r_grant];
    assign out_rule_eop   = w_eop_arr[r_grant];
    assign out_rule_empty = w_empty_arr[r_grant];
    assign out_rule_data  = w_data_arr[r_grant];
    assign w_xfer_eop     = out_rule_valid && out_rule_ready && out_rule_eop;
    assign cur_grant      = r_grant;

    // First requester after the last completed grant, wrapping modulo NUM_PORTS.
    always_comb begin
        int            idx;
        logic [GW-1:0] sel;
        w_found = 1'b0;
        w_pick  = r_last_grant;
        idx     = 0;
        sel     = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            idx = (int'(r_last_grant) + k) % NUM_PORTS;
            sel = GW'(idx);
            if (!w_found && in_rule_valid[sel]) begin
                w_found = 1'b1;
                w_pick  = sel;
            end
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_grant_next      = r_grant;
        w_last_grant_next = r_last_grant;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_grant_next = w_pick;
                    w_state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                if (w_xfer_eop) begin
                    w_last_grant_next = r_grant;
                    w_state_next      = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_grant      <= GW'(NUM_PORTS - 1);
            r_last_grant <= GW'(NUM_PORTS - 1);
        end else begin
            r_state      <= w_state_next;
            r_grant      <= w_grant_next;
            r_last_grant <= w_last_grant_next;
        end
    end

`ifdef RULE_ARB_STATS_EN
    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_stats
            logic [CNT_W-1:0] r_cnt;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (w_xfer_eop && (r_grant == GW'(gi))) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
            assign pkt_cnt[CNT_W*gi +: CNT_W] = r_cnt;
        end
    endgenerate
`else
    assign pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_rule_stream_arbiter.sv
// Self-checking bench for rule_stream_arbiter: packet-level round-robin scoreboard
// with randomized data, lengths, gaps and downstream backpressure.
module tb_rule_stream_arbiter;
    localparam int N     = 4;
    localparam int CNT_W = 32;

    typedef struct packed {
        logic        sop;
        logic        eop;
        logic [2:0]  empty;
        logic [63:0] data;
    } beat_t;

    logic              clk;
    logic              rst;
    logic [N-1:0]      in_rule_sop;
    logic [N-1:0]      in_rule_eop;
    logic [N*3-1:0]    in_rule_empty;
    logic [N-1:0]      in_rule_valid;
    logic [N*64-1:0]   in_rule_data;
    logic [N-1:0]      in_rule_ready;
    logic              out_rule_sop;
    logic              out_rule_eop;
    logic [2:0]        out_rule_empty;
    logic              out_rule_valid;
    logic [63:0]       out_rule_data;
    logic              out_rule_ready;
    logic [1:0]        cur_grant;
    logic [N*CNT_W-1:0] pkt_cnt;

    rule_stream_arbiter #(.NUM_PORTS(N), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_rule_sop    (in_rule_sop),
        .in_rule_eop    (in_rule_eop),
        .in_rule_empty  (in_rule_empty),
        .in_rule_valid  (in_rule_valid),
        .in_rule_data   (in_rule_data),
        .in_rule_ready  (in_rule_ready),
        .out_rule_sop   (out_rule_sop),
        .out_rule_eop   (out_rule_eop),
        .out_rule_empty (out_rule_empty),
        .out_rule_valid (out_rule_valid),
        .out_rule_data  (out_rule_data),
        .out_rule_ready (out_rule_ready),
        .cur_grant      (cur_grant),
        .pkt_cnt        (pkt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_chk;
    int    n_fail;
    beat_t pq [N][$];
    int    model_last;
    int    model_cur;
    int    cnt [N];
    int    beats_in_pkt;
    int    cyc;
    int    ready_mode;
    bit    gap_en;
    bit    tog;
    int    sop_cycles[$];
    int    grant_log[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_pkt(input int p, input int len, input bit zero);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.sop   = (i == 0);
            b.eop   = (i == len - 1);
            b.empty = (zero || i != len - 1) ? 3'd0 : 3'($urandom_range(0, 7));
            b.data  = zero ? 64'd0 : {$urandom, $urandom};
            pq[p].push_back(b);
        end
    endtask

    function automatic int pick_next();
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (model_last + k) % N;
            if (pq[idx].size() > 0) return idx;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int p);
        logic [N-1:0] v;
        v = '0;
        v[p] = 1'b1;
        return v;
    endfunction

    task automatic step();
        beat_t b;
        // drive inputs for this cycle
        in_rule_sop = '0; in_rule_eop = '0; in_rule_valid = '0;
        in_rule_empty = '0; in_rule_data = '0;
        for (int p = 0; p < N; p++) begin
            if (pq[p].size() > 0) begin
                b = pq[p][0];
                in_rule_valid[p]        = b.sop || !gap_en || ($urandom_range(0, 3) != 0);
                in_rule_sop[p]          = b.sop;
                in_rule_eop[p]          = b.eop;
                in_rule_empty[3*p +: 3] = b.empty;
                in_rule_data[64*p +: 64] = b.data;
            end
        end
        case (ready_mode)
            1:       out_rule_ready = 1'($urandom_range(0, 1));
            2: begin tog = ~tog; out_rule_ready = tog; end
            default: out_rule_ready = 1'b1;
        endcase
        #4;
        if (out_rule_valid) begin
            if (model_cur < 0) model_cur = pick_next();
            if (model_cur < 0) begin
                chk("spurious_valid", 64'(out_rule_valid), 64'd0);
            end else begin
                b = pq[model_cur][0];
                chk("grant", 64'(cur_grant), 64'(model_cur));
                chk("in_ready", 64'(in_rule_ready),
                    64'(out_rule_ready ? onehot(model_cur) : 4'b0));
                chk("data", out_rule_data, b.data);
                chk("sop", 64'(out_rule_sop), 64'(b.sop));
                chk("eop", 64'(out_rule_eop), 64'(b.eop));
                chk("empty", 64'(out_rule_empty), 64'(b.empty));
                if (out_rule_ready) begin
                    void'(pq[model_cur].pop_front());
                    beats_in_pkt++;
                    if (b.sop) begin
                        sop_cycles.push_back(cyc);
                        grant_log.push_back(int'(cur_grant));
                    end
                    if (b.eop) begin
                        $display("pkt port=%0d beats=%0d cyc=%0d", model_cur, beats_in_pkt, cyc);
                        cnt[model_cur]++;
                        model_last   = model_cur;
                        model_cur    = -1;
                        beats_in_pkt = 0;
                    end
                end
            end
        end else if (model_cur < 0) begin
            chk("idle_ready", 64'(in_rule_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_all(input int max_cyc);
        int n;
        bit busy;
        n = 0;
        busy = 1'b1;
        while (busy && n < max_cyc) begin
            step();
            n++;
            busy = (model_cur >= 0);
            for (int p = 0; p < N; p++) if (pq[p].size() > 0) busy = 1'b1;
        end
        if (busy) chk("timeout", 64'd1, 64'd0);
    endtask

    task automatic check_cnts();
        for (int p = 0; p < N; p++) begin
`ifdef RULE_ARB_STATS_EN
            chk("pkt_cnt", 64'(pkt_cnt[CNT_W*p +: CNT_W]), 64'(cnt[p]));
`else
            chk("pkt_cnt", 64'(pkt_cnt[CNT_W*p +: CNT_W]), 64'd0);
`endif
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < N; p++) begin
            pq[p].delete();
            cnt[p] = 0;
        end
        model_last   = N - 1;
        model_cur    = -1;
        beats_in_pkt = 0;
    endtask

    initial begin
        n_chk = 0; n_fail = 0; cyc = 0; tog = 1'b0;
        ready_mode = 0; gap_en = 1'b0;
        rst = 1'b1; out_rule_ready = 1'b1;
        in_rule_sop = '0; in_rule_eop = '0; in_rule_valid = '0;
        in_rule_empty = '0; in_rule_data = '0;
        model_reset();
        @(posedge clk);
        #1;

        // Reset with every port requesting: nothing may move
        for (int p = 0; p < N; p++) begin
            push_pkt(p, 3, 1'b0);
            push_pkt(p, 3, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_out_valid", 64'(out_rule_valid), 64'd0);
            chk("rst_in_ready", 64'(in_rule_ready), 64'd0);
        end
        chk("rst_cur_grant", 64'(cur_grant), 64'(N - 1));
        check_cnts();

        // Round-robin at full rate: order 0..3,0..3 and 4 cycles per packet
        rst = 1'b0;
        cyc = 0;
        sop_cycles.delete();
        grant_log.delete();
        run_all(200);
        chk("rr_npkts", 64'(grant_log.size()), 64'(2 * N));
        if (sop_cycles.size() > 0) chk("first_sop_cycle", 64'(sop_cycles[0]), 64'd1);
        for (int i = 0; i < grant_log.size(); i++)
            chk("rr_order", 64'(grant_log[i]), 64'(i % N));
        for (int i = 1; i < sop_cycles.size(); i++)
            chk("pkt_period", 64'(sop_cycles[i] - sop_cycles[i-1]), 64'd4);
        check_cnts();

        // Random lengths, mid-packet gaps and random downstream ready
        ready_mode = 1;
        gap_en = 1'b1;
        for (int r = 0; r < 4; r++) begin
            for (int p = 0; p < N; p++) begin
                int np;
                np = $urandom_range(0, 4);
                for (int k = 0; k < np; k++) push_pkt(p, $urandom_range(1, 5), 1'b0);
            end
            run_all(2000);
        end
        check_cnts();

        // Single-beat zero packets on ports 2 and 3 after a port-1 packet
        ready_mode = 0;
        gap_en = 1'b0;
        push_pkt(1, 2, 1'b0);
        run_all(50);
        grant_log.delete();
        push_pkt(2, 1, 1'b1);
        push_pkt(3, 1, 1'b1);
        run_all(50);
        chk("single_npkts", 64'(grant_log.size()), 64'd2);
        if (grant_log.size() == 2) begin
            chk("single_first", 64'(grant_log[0]), 64'd2);
            chk("single_second", 64'(grant_log[1]), 64'd3);
        end

        // Toggling backpressure during a 5-beat packet
        ready_mode = 2;
        push_pkt(0, 5, 1'b0);
        run_all(100);

        // Stats: 5 packets on port 1, 2 on port 3
        ready_mode = 1;
        for (int k = 0; k < 5; k++) push_pkt(1, $urandom_range(1, 4), 1'b0);
        for (int k = 0; k < 2; k++) push_pkt(3, $urandom_range(1, 4), 1'b0);
        run_all(500);
        check_cnts();

        // Reset in the middle of a packet
        ready_mode = 0;
        push_pkt(2, 5, 1'b0);
        for (int i = 0; i < 3; i++) step();
        chk("mid_pkt_busy", 64'(model_cur), 64'd2);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("midrst_out_valid", 64'(out_rule_valid), 64'd0);
            chk("midrst_in_ready", 64'(in_rule_ready), 64'd0);
        end
        model_reset();
        check_cnts();
        chk("midrst_cur_grant", 64'(cur_grant), 64'(N - 1));
        rst = 1'b0;
        grant_log.delete();
        push_pkt(3, 2, 1'b0);
        push_pkt(1, 3, 1'b0);
        run_all(100);
        chk("post_rst_npkts", 64'(grant_log.size()), 64'd2);
        if (grant_log.size() == 2) begin
            chk("post_rst_first", 64'(grant_log[0]), 64'd1);
            chk("post_rst_second", 64'(grant_log[1]), 64'd3);
        end
        check_cnts();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
